// File: rtl/testio_target.sv
// testio_target: responder end of the testio serial link.
//
// Receives host write/read frames on ti_din (one beat per clock, multi-beat
// fields MSB beat first). Each good frame becomes one bus request. The ACK
// (write) or read data (read) is then sent back on ti_dout, and the link is
// driven only while that reply is on the wire.
//
// Optional feature macro: TESTIO_TGT_PARITY_CHK_EN
//   defined   : the received PAR beat is checked. On a mismatch, frame_err
//               pulses, no bus access is made, and an error reply is sent.
//   undefined : the PAR beat is consumed and ignored.
//
// Ports
//   ti_clk, ti_rstn     clock (posedge) and async active-low reset
//   ti_din              link data from the host
//   ti_dout, ti_doen    link data to the host; doen 0 = drive, 1 = input
//   bus_req_*           bus request; valid/ready handshake
//   bus_resp_*          one-cycle response pulse with data and error
//   busy                high whenever the FSM is outside IDLE
//   frame_err           one-cycle pulse on a bad STOP or a parity error
//   dbg_state           current FSM state, for observation
//
// Handshake: bus_req_valid rises the cycle after a good STOP beat is sampled.
// The request fields hold steady until a clock edge that sees
// bus_req_valid && bus_req_ready. bus_resp_valid is sampled only in BUS_WAIT,
// which is entered on the edge after acceptance. A response in the acceptance
// cycle itself is therefore not seen.
module testio_target #(
  parameter int DATA_W = 32,
  parameter int MASK_W = 4,
  parameter int TI_W   = 1
) (
  input  logic              ti_clk,
  input  logic              ti_rstn,
  input  logic [TI_W-1:0]   ti_din,
  output logic [TI_W-1:0]   ti_dout,
  output logic [TI_W-1:0]   ti_doen,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_req_type,
  output logic [DATA_W-1:0] bus_req_addr,
  output logic [DATA_W-1:0] bus_req_data,
  output logic [MASK_W-1:0] bus_req_strb,
  input  logic              bus_resp_valid,
  input  logic [DATA_W-1:0] bus_resp_data,
  input  logic              bus_resp_err,
  output logic              busy,
  output logic              frame_err,
  output logic [3:0]        dbg_state
);

  localparam int         D_BEATS = DATA_W / TI_W;
  localparam logic [7:0] D_LAST  = 8'(D_BEATS - 1);
  // One strobe bit per beat on a 1-bit link; otherwise the strobe fits in one beat.
  localparam logic [7:0] S_LAST  = (TI_W == 1) ? 8'(MASK_W - 1) : 8'd0;

`ifdef TESTIO_TGT_PARITY_CHK_EN
  localparam bit PAR_CHK = 1'b1;
`else
  localparam bit PAR_CHK = 1'b0;
`endif

  typedef enum logic [3:0] {
    IDLE, RX_TYPE, RX_ADDR, RX_STRB, RX_DATA, RX_PAR, RX_STOP,
    BUS_REQ, BUS_WAIT, TURN, TX_START, TX_BODY, TX_PAR, TX_STOP
  } state_t;

  state_t            state_q;
  logic [7:0]        cnt_q;
  logic              type_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MASK_W-1:0] strb_q;
  logic [MASK_W-1:0] strb_d;
  logic [TI_W-1:0]   rx_par_q;
  logic              par_bad_q;
  logic              req_valid_q;
  logic [DATA_W-1:0] rdata_q;     // captured read data; also the reply shift register
  logic              rerr_q;
  logic [TI_W-1:0]   tx_par_q;
  logic [TI_W-1:0]   dout_q;
  logic [TI_W-1:0]   doen_q;
  logic              ferr_q;

  // Next strobe value: shifted in bit by bit on a 1-bit link, or taken from one beat.
  if (TI_W == 1) begin : g_strb_serial
    assign strb_d = {strb_q[MASK_W-2:0], ti_din[0]};
  end else begin : g_strb_beat
    assign strb_d = ti_din[MASK_W-1:0];
  end

  // XOR of all TI_W-wide beats of a data word (the read-reply parity).
  function automatic logic [TI_W-1:0] fold(input logic [DATA_W-1:0] d);
    logic [TI_W-1:0] r;
    r = '0;
    for (int i = 0; i < D_BEATS; i++) r = r ^ d[i*TI_W +: TI_W];
    return r;
  endfunction

  always_ff @(posedge ti_clk or negedge ti_rstn) begin
    if (!ti_rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      type_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
      rx_par_q    <= '0;
      par_bad_q   <= 1'b0;
      req_valid_q <= 1'b0;
      rdata_q     <= '0;
      rerr_q      <= 1'b0;
      tx_par_q    <= '0;
      dout_q      <= '1;
      doen_q      <= '1;
      ferr_q      <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!ti_din[0]) begin
            rx_par_q  <= ti_din;
            par_bad_q <= 1'b0;
            state_q   <= RX_TYPE;
          end
        end
        RX_TYPE: begin
          type_q   <= ti_din[0];
          rx_par_q <= rx_par_q ^ ti_din;
          cnt_q    <= D_LAST;
          if (!ti_din[0]) strb_q <= '1;
          state_q  <= RX_ADDR;
        end
        RX_ADDR: begin
          addr_q   <= {addr_q[DATA_W-TI_W-1:0], ti_din};
          rx_par_q <= rx_par_q ^ ti_din;
          if (cnt_q == 8'd0) begin
            if (type_q) begin
              cnt_q   <= S_LAST;
              state_q <= RX_STRB;
            end else begin
              state_q <= RX_PAR;
            end
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        RX_STRB: begin
          strb_q   <= strb_d;
          rx_par_q <= rx_par_q ^ ti_din;
          if (cnt_q == 8'd0) begin
            cnt_q   <= D_LAST;
            state_q <= RX_DATA;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        RX_DATA: begin
          wdata_q  <= {wdata_q[DATA_W-TI_W-1:0], ti_din};
          rx_par_q <= rx_par_q ^ ti_din;
          if (cnt_q == 8'd0) state_q <= RX_PAR;
          else               cnt_q   <= cnt_q - 8'd1;
        end
        RX_PAR: begin
          par_bad_q <= (ti_din != rx_par_q);
          state_q   <= RX_STOP;
        end
        RX_STOP: begin
          if (!ti_din[0]) begin
            ferr_q  <= 1'b1;
            state_q <= IDLE;
          end else if (PAR_CHK && par_bad_q) begin
            // Skip the bus and reply as if the bus had failed with zero data.
            ferr_q  <= 1'b1;
            rdata_q <= '0;
            rerr_q  <= 1'b1;
            state_q <= TURN;
          end else begin
            req_valid_q <= 1'b1;
            state_q     <= BUS_REQ;
          end
        end
        BUS_REQ: begin
          if (bus_req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= BUS_WAIT;
          end
        end
        BUS_WAIT: begin
          if (bus_resp_valid) begin
            rdata_q <= bus_resp_data;
            rerr_q  <= bus_resp_err;
            state_q <= TURN;
          end
        end
        TURN: begin
          // The link stays released for this cycle; the START beat is loaded here.
          tx_par_q <= fold(rdata_q) ^ {TI_W{rerr_q}};
          dout_q   <= '0;
          doen_q   <= '0;
          state_q  <= TX_START;
        end
        TX_START: begin
          if (type_q) begin
            dout_q <= {TI_W{rerr_q}};
            cnt_q  <= 8'd0;
          end else begin
            dout_q  <= rdata_q[DATA_W-1 -: TI_W];
            rdata_q <= rdata_q << TI_W;
            cnt_q   <= D_LAST;
          end
          state_q <= TX_BODY;
        end
        TX_BODY: begin
          if (cnt_q == 8'd0) begin
            if (type_q) begin
              dout_q  <= '1;
              state_q <= TX_STOP;
            end else begin
              dout_q  <= tx_par_q;
              state_q <= TX_PAR;
            end
          end else begin
            dout_q  <= rdata_q[DATA_W-1 -: TI_W];
            rdata_q <= rdata_q << TI_W;
            cnt_q   <= cnt_q - 8'd1;
          end
        end
        TX_PAR: begin
          dout_q  <= '1;
          state_q <= TX_STOP;
        end
        TX_STOP: begin
          dout_q  <= '1;
          doen_q  <= '1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ti_dout       = dout_q;
  assign ti_doen       = doen_q;
  assign bus_req_valid = req_valid_q;
  assign bus_req_type  = type_q;
  assign bus_req_addr  = addr_q;
  assign bus_req_data  = wdata_q;
  assign bus_req_strb  = strb_q;
  assign busy          = (state_q != IDLE);
  assign frame_err     = ferr_q;
  assign dbg_state     = state_q;

endmodule
